// File: rtl/pipe_pkg.sv
`default_nettype none
// ============================================================================
// Module   : pipe_pkg
// Purpose  : Shared constants for the core pipeline boundary registers:
//            control bus width, the no-side-effect control encoding, the
//            control field layout and per-boundary datapath widths.
// Revision : 1.0 - initial release
// ============================================================================
package pipe_pkg;

  // Control bus: {wdsel[1:0], rfwe, dmwe}
  localparam int CTRL_W          = 4;
  localparam int CTRL_DMWE_BIT   = 0;
  localparam int CTRL_RFWE_BIT   = 1;
  localparam int CTRL_WDSEL_LSB  = 2;
  localparam int CTRL_WDSEL_W    = 2;

  // All-zero control: no register write, no memory write, wdsel don't-care.
  localparam logic [CTRL_W-1:0] CTRL_NOP = '0;

  // Datapath payload widths at each stage boundary (32-bit fields).
  localparam int IFID_W  = 96;   // pc, pc4, inst
  localparam int IDEX_W  = 160;  // pc4, rs1, rs2, imm, inst
  localparam int EXMEM_W = 128;  // pc4, alu, rs2, inst
  localparam int MEMWB_W = 128;  // pc4, alu, mem rdata, inst

  typedef struct packed {
    logic [CTRL_WDSEL_W-1:0] wdsel;
    logic                    rfwe;
    logic                    dmwe;
  } ctrl_t;

  // True when a control word can cause no architectural side effect.
  function automatic logic ctrl_is_safe(input logic [CTRL_W-1:0] c);
    return !c[CTRL_RFWE_BIT] && !c[CTRL_DMWE_BIT];
  endfunction

endpackage
`default_nettype wire

// File: rtl/sat_counter.sv
`default_nettype none
// ============================================================================
// Module   : sat_counter
// Purpose  : Up-counter that sticks at all-ones, with synchronous clear that
//            takes priority over increment.
// Ports    : clk, rst_n (async active-low), clr (sync clear), inc (count
//            enable), cnt (registered count, W bits)
// Revision : 1.0 - initial release
// ============================================================================
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] cnt
);

  logic [W-1:0] r_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (clr) begin
      r_cnt <= '0;
    end else if (inc && (r_cnt != {W{1'b1}})) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign cnt = r_cnt;

endmodule
`default_nettype wire

// File: rtl/pipe_stage_reg.sv
`default_nettype none
// ============================================================================
// Module   : pipe_stage_reg
// Purpose  : Pipeline boundary register with valid bit, stall (hold) and
//            flush (bubble). Edge priority is flush > stall > load. The
//            control payload is forced to CTRL_NOP whenever the stage holds
//            no valid instruction, so a bubble never has side effects.
//            Optional build macro PIPE_STAGE_PERF_EN adds saturating
//            stall/bubble counters; without it they read as zero.
// Ports    : clk, rst_n (async active-low)
//            in_valid/in_data/in_ctrl   upstream payload
//            stall, flush, perf_clr     per-edge controls
//            out_valid/out_data/out_ctrl registered payload
//            perf_stall_cnt, perf_bubble_cnt  performance counters
// Revision : 1.0 - initial release
// ============================================================================
module pipe_stage_reg #(
  parameter int                  DATA_W   = 128,
  parameter int                  CTRL_W   = pipe_pkg::CTRL_W,
  parameter logic [CTRL_W-1:0]   CTRL_NOP = {CTRL_W{1'b0}},
  parameter int                  CNT_W    = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic              stall,
  input  logic              flush,
  input  logic              perf_clr,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [CNT_W-1:0]  perf_stall_cnt,
  output logic [CNT_W-1:0]  perf_bubble_cnt
);

  import pipe_pkg::*;

  logic              r_valid;
  logic [DATA_W-1:0] r_data;
  logic [CTRL_W-1:0] r_ctrl;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= 1'b0;
      r_data  <= '0;
      r_ctrl  <= CTRL_NOP;
    end else if (flush) begin
      // Flush overrides a simultaneous stall.
      r_valid <= 1'b0;
      r_data  <= '0;
      r_ctrl  <= CTRL_NOP;
    end else if (!stall) begin
      r_valid <= in_valid;
      r_data  <= in_data;
      // Invalid input never carries live control downstream.
      r_ctrl  <= in_valid ? in_ctrl : CTRL_NOP;
    end
  end

  assign out_valid = r_valid;
  assign out_data  = r_data;
  assign out_ctrl  = r_ctrl;

`ifdef PIPE_STAGE_PERF_EN
  // Only stalls that actually hold an instruction count; a bubble is
  // either a flush or a load of an empty slot.
  logic w_stall_inc;
  logic w_bubble_inc;

  assign w_stall_inc  = stall & ~flush & r_valid;
  assign w_bubble_inc = flush | (~stall & ~in_valid);

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (perf_clr),
    .inc   (w_stall_inc),
    .cnt   (perf_stall_cnt)
  );

  sat_counter #(.W(CNT_W)) u_bubble_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (perf_clr),
    .inc   (w_bubble_inc),
    .cnt   (perf_bubble_cnt)
  );
`else
  // Counters compiled out: outputs read as zero and perf_clr is ignored.
  logic w_unused_perf;
  assign w_unused_perf   = perf_clr;
  assign perf_stall_cnt  = '0;
  assign perf_bubble_cnt = '0;
`endif

endmodule
`default_nettype wire

// File: doc/pipe_stage_reg.md
# pipe_stage_reg

Parametrised pipeline stage register with per-stage valid bit, stall (hold) and flush (bubble insertion). It is the drop-in successor for the fixed inter-stage registers (IF/ID, ID/EX, EX/MEM, MEM/WB): each stage boundary instantiates one copy. Its payload is a concatenated data bus and a control bus, and the control bus is forced to a safe value on bubbles. An optional performance-counter block counts stall and bubble cycles per stage.

## Interface
Parameters:
- DATA_W, 128, width of the datapath payload (pc, pc4, inst, operands, ALU result, etc., concatenated).
- CTRL_W, 4, width of the control payload (e.g. wdsel, rfwe, dmwe).
- CTRL_NOP, {CTRL_W{1'b0}}, control value loaded on reset and bubbles; must encode "no architectural side effect".
- CNT_W, 16, width of each performance counter.

Ports:
- clk  input  1  stage clock; all state updates on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  upstream stage holds a real instruction.
- in_data  input  DATA_W  upstream datapath payload.
- in_ctrl  input  CTRL_W  upstream control payload.
- stall  input  1  hold current contents this cycle.
- flush  input  1  replace contents with a bubble this cycle.
- perf_clr  input  1  synchronous clear of both counters.
- out_valid  output  1  registered valid.
- out_data  output  DATA_W  registered datapath payload.
- out_ctrl  output  CTRL_W  registered control payload.
- perf_stall_cnt  output  CNT_W  saturating count of held-valid cycles.
- perf_bubble_cnt  output  CNT_W  saturating count of bubble loads.

## Operation
- Three actions per edge, priority flush > stall > load.
- Flush: out_valid<=0, out_ctrl<=CTRL_NOP, out_data<=0. Flush also overrides a simultaneous stall.
- Stall (flush=0): all outputs hold their values. in_* are ignored.
- Load (flush=0, stall=0): out_valid<=in_valid, out_data<=in_data. out_ctrl<=in_ctrl if in_valid=1, else CTRL_NOP. An invalid input therefore never carries live control.
- Invariant: out_valid=0 implies out_ctrl==CTRL_NOP.
- Stall counter increments on an edge where stall=1, flush=0 and out_valid=1. Stalling an empty stage does not count.
- Bubble counter increments on an edge where flush=1, or where a load occurs with in_valid=0.
- Both counters saturate at all-ones and never wrap.
- perf_clr=1 sets both counters to 0 on that edge, overriding any increment.

## Timing
- Latency: 1 cycle from in_* to out_* on a load edge.
- Reset (rst_n=0, immediate, asynchronous): out_valid=0, out_data=0, out_ctrl=CTRL_NOP, both counters=0.
- Reset asserted mid-stall or mid-flush: reset wins immediately. The first edge after deassertion is evaluated normally.
- No combinational path from any input to any output. All outputs come straight from flops.
- stall and flush are sampled only at the rising edge. Glitches between edges have no effect.

## Configuration
- PIPE_STAGE_PERF_EN defined: both counters, perf_clr handling and the saturation logic are compiled in.
- PIPE_STAGE_PERF_EN undefined: no counter flops are built. perf_stall_cnt and perf_bubble_cnt are tied to 0 and perf_clr is ignored. The port list is unchanged.

## Structure
- Shared package pipe_pkg holds:
  - CTRL_W for the core;
  - the CTRL_NOP encoding;
  - the control field layout (wdsel 2 bits, rfwe, dmwe) with named field offsets;
  - per-boundary DATA_W constants (IFID_W, IDEX_W, EXMEM_W, MEMWB_W).
- Sub-module sat_counter (parameter W; inputs clk, rst_n, clr, inc; output cnt) is instantiated twice, under PIPE_STAGE_PERF_EN only.

## Test plan
- Reset, then load in_valid=1, in_data=128'h...DEADBEEF, in_ctrl=4'b1011 -> one edge later out_valid=1, out_data matches, out_ctrl=4'b1011.
- Valid contents held, stall=1 for 3 edges while in_data changes -> outputs unchanged. perf_stall_cnt=3 with PERF_EN, 0 without.
- stall=1 and flush=1 on the same edge with valid contents -> out_valid=0, out_ctrl=CTRL_NOP, out_data=0. perf_bubble_cnt +1, perf_stall_cnt unchanged.
- Load with in_valid=0, in_ctrl=4'b1111 -> out_valid=0, out_ctrl=CTRL_NOP, perf_bubble_cnt +1.
- CNT_W=4: 20 consecutive stall edges on valid contents -> perf_stall_cnt sticks at 15. Then perf_clr=1 with stall=1 -> 0 on that edge.
- Assert rst_n=0 between edges while stalled with valid contents -> outputs go to reset values immediately, before the next edge.
